// File: rtl/render_pkg.sv
// Shared types and default widths for the render-loop scheduler.
package render_pkg;

  localparam int FRAME_W = 16;
  localparam int LATE_W  = 8;
  localparam int STAT_W  = 24;

  typedef enum logic [2:0] {
    Idle,
    Clear,
    Proj,
    Draw,
    Hold,
    Swap
  } frame_sched_state_t;

  // States in which a frame is still being rendered (a vsync here is a miss).
  function automatic logic isRenderState(input frame_sched_state_t s);
    return (s == Clear) || (s == Proj) || (s == Draw);
  endfunction

endpackage

// File: rtl/frame_sched_rise_detect.sv
// Rising-edge detector with a registered previous value that resets high,
// so a level already asserted out of reset is not reported as an edge.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/frame_sched.sv
// Per-frame render scheduler: clear -> project -> draw -> hold -> swap at vsync.
// Optional render-cycle statistic is built when FRAME_SCHED_STATS_EN is defined.
module frame_sched
  import render_pkg::*;
#(
  parameter int FRAME_W = render_pkg::FRAME_W,
  parameter int LATE_W  = render_pkg::LATE_W,
  parameter int STAT_W  = render_pkg::STAT_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic               vsync,
  output logic               clear_start,
  input  logic               clear_done,
  output logic               proj_start,
  input  logic               proj_done,
  output logic               draw_start,
  input  logic               draw_done,
  output logic               back_buf,
  output logic [FRAME_W-1:0] frame_count,
  output logic [LATE_W-1:0]  late_count,
  output logic               late,
  output logic               busy,
  output logic [STAT_W-1:0]  render_cycles
);

  frame_sched_state_t state_q, state_d;

  logic               firstCycle_q, firstCycle_d;
  logic               clearStart_q, clearStart_d;
  logic               projStart_q, projStart_d;
  logic               drawStart_q, drawStart_d;
  logic               backBuf_q, backBuf_d;
  logic               late_q, late_d;
  logic [FRAME_W-1:0] frameCount_q, frameCount_d;
  logic [LATE_W-1:0]  lateCount_q, lateCount_d;

  logic vsyncRise;
  logic drawAccept;

  rise_detect u_vsyncRise (
    .Clk    (Clk),
    .Reset  (Reset),
    .sig_i  (vsync),
    .rise_o (vsyncRise)
  );

  // Done inputs only count after the first cycle of a stage, so a level
  // left high by the previous frame cannot skip the stage.
  assign drawAccept = (state_q == Draw) && draw_done && !firstCycle_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= Idle;
      firstCycle_q <= 1'b0;
      clearStart_q <= 1'b0;
      projStart_q  <= 1'b0;
      drawStart_q  <= 1'b0;
      backBuf_q    <= 1'b0;
      late_q       <= 1'b0;
      frameCount_q <= '0;
      lateCount_q  <= '0;
    end else begin
      state_q      <= state_d;
      firstCycle_q <= firstCycle_d;
      clearStart_q <= clearStart_d;
      projStart_q  <= projStart_d;
      drawStart_q  <= drawStart_d;
      backBuf_q    <= backBuf_d;
      late_q       <= late_d;
      frameCount_q <= frameCount_d;
      lateCount_q  <= lateCount_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (enable && vsyncRise) state_d = Clear;
      Clear:   if (clear_done && !firstCycle_q) state_d = Proj;
      Proj:    if (proj_done && !firstCycle_q) state_d = Draw;
      Draw:    if (drawAccept) state_d = vsyncRise ? Swap : Hold;
      Hold:    if (vsyncRise) state_d = Swap;
      Swap:    state_d = enable ? Clear : Idle;
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    firstCycle_d = (state_d != state_q);
    clearStart_d = (state_d == Clear) && (state_q != Clear);
    projStart_d  = (state_d == Proj) && (state_q != Proj);
    drawStart_d  = (state_d == Draw) && (state_q != Draw);

    // A vsync that lands while rendering is a miss, unless draw finishes on it.
    late_d      = vsyncRise && isRenderState(state_q) && !drawAccept;
    lateCount_d = lateCount_q;
    if (late_d && (lateCount_q != '1)) begin
      lateCount_d = lateCount_q + LATE_W'(1);
    end

    backBuf_d    = backBuf_q;
    frameCount_d = frameCount_q;
    if (state_q == Swap) begin
      backBuf_d    = ~backBuf_q;
      frameCount_d = frameCount_q + FRAME_W'(1);
    end

    busy = (state_q != Idle);
  end

  assign clear_start = clearStart_q;
  assign proj_start  = projStart_q;
  assign draw_start  = drawStart_q;
  assign back_buf    = backBuf_q;
  assign frame_count = frameCount_q;
  assign late_count  = lateCount_q;
  assign late        = late_q;

`ifdef FRAME_SCHED_STATS_EN
  logic [STAT_W-1:0] statCnt_q, statCnt_d;
  logic [STAT_W-1:0] renderCycles_q, renderCycles_d;

  // The count includes the current cycle, so the latched value equals the
  // number of cycles spent in Clear, Proj and Draw.
  always_comb begin
    statCnt_d      = statCnt_q;
    renderCycles_d = renderCycles_q;
    if ((state_q == Clear) && firstCycle_q) begin
      statCnt_d = STAT_W'(1);
    end else if (isRenderState(state_q) && (statCnt_q != '1)) begin
      statCnt_d = statCnt_q + STAT_W'(1);
    end
    if ((state_q == Draw) && ((state_d == Hold) || (state_d == Swap))) begin
      renderCycles_d = statCnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      statCnt_q      <= '0;
      renderCycles_q <= '0;
    end else begin
      statCnt_q      <= statCnt_d;
      renderCycles_q <= renderCycles_d;
    end
  end

  assign render_cycles = renderCycles_q;
`else
  assign render_cycles = '0;
`endif

endmodule

// File: tb/tb_frame_sched.sv
// Directed self-checking bench for frame_sched: a default-width instance and
// a FRAME_W=2 / LATE_W=2 instance for the wrap and saturation cases.
module tb_frame_sched;

`ifdef FRAME_SCHED_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic        enable, vsync, clear_done, proj_done, draw_done;
  logic        clear_start, proj_start, draw_start, back_buf, late, busy;
  logic [15:0] frame_count;
  logic [7:0]  late_count;
  logic [23:0] render_cycles;

  logic        sEnable, sVsync, sClearDone, sProjDone, sDrawDone;
  logic        sClearStart, sProjStart, sDrawStart, sBack, sLate, sBusy;
  logic [1:0]  sFrame;
  logic [1:0]  sLateCount;
  logic [23:0] sRender;

  int checks = 0;
  int errors = 0;

  frame_sched dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .vsync(vsync),
    .clear_start(clear_start), .clear_done(clear_done),
    .proj_start(proj_start), .proj_done(proj_done),
    .draw_start(draw_start), .draw_done(draw_done),
    .back_buf(back_buf), .frame_count(frame_count), .late_count(late_count),
    .late(late), .busy(busy), .render_cycles(render_cycles)
  );

  frame_sched #(.FRAME_W(2), .LATE_W(2)) dutSmall (
    .Clk(Clk), .Reset(Reset), .enable(sEnable), .vsync(sVsync),
    .clear_start(sClearStart), .clear_done(sClearDone),
    .proj_start(sProjStart), .proj_done(sProjDone),
    .draw_start(sDrawStart), .draw_done(sDrawDone),
    .back_buf(sBack), .frame_count(sFrame), .late_count(sLateCount),
    .late(sLate), .busy(sBusy), .render_cycles(sRender)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset(input logic vs);
    Reset = 1'b1; enable = 1'b0; vsync = vs;
    clear_done = 1'b0; proj_done = 1'b0; draw_done = 1'b0;
    sEnable = 1'b0; sVsync = 1'b0;
    sClearDone = 1'b0; sProjDone = 1'b0; sDrawDone = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    doReset(1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({clear_start, proj_start, draw_start} !== 3'b000) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 000", {clear_start, proj_start, draw_start}); end
    checks++; if (back_buf !== 1'b0) begin errors++; $display("[TB] FAIL reset_back_buf: got %b want 0", back_buf); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_count: got %0d want 0", frame_count); end
    checks++; if (late_count !== 8'd0 || late !== 1'b0) begin errors++; $display("[TB] FAIL reset_late: got cnt %0d pulse %b want 0 0", late_count, late); end
    checks++; if (render_cycles !== 24'd0) begin errors++; $display("[TB] FAIL reset_render_cycles: got %0d want 0", render_cycles); end
    for (int c = 0; c <= 11; c++) begin
      tick();
      vsync = ((c % 4) == 0);
      checks++; if (busy !== 1'b0 || clear_start !== 1'b0) begin errors++; $display("[TB] FAIL disabled_idle c%0d: got busy %b clear_start %b want 0 0", c, busy, clear_start); end
    end
    checks++; if (frame_count !== 16'd0 || late_count !== 8'd0) begin errors++; $display("[TB] FAIL disabled_counters: got %0d %0d want 0 0", frame_count, late_count); end
  endtask

  task automatic test_vsync_high_at_reset();
    doReset(1'b1);
    enable = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      checks++; if (busy !== 1'b0 || clear_start !== 1'b0) begin errors++; $display("[TB] FAIL vsync_high_reset c%0d: got busy %b clear_start %b want 0 0", c, busy, clear_start); end
    end
    vsync = 1'b0;
  endtask

  task automatic test_normal_frame();
    doReset(1'b0);
    enable = 1'b1;
    for (int c = 0; c <= 104; c++) begin
      tick();
      vsync = (c == 0) || (c == 100);
      clear_done = (c == 5); proj_done = (c == 20); draw_done = (c == 50);
      checks++; if (clear_start !== ((c == 1) || (c == 102))) begin errors++; $display("[TB] FAIL normal_clear_start c%0d: got %b", c, clear_start); end
      checks++; if (proj_start !== (c == 6)) begin errors++; $display("[TB] FAIL normal_proj_start c%0d: got %b", c, proj_start); end
      checks++; if (draw_start !== (c == 21)) begin errors++; $display("[TB] FAIL normal_draw_start c%0d: got %b", c, draw_start); end
      if (c == 0) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL normal_busy_idle: got %b want 0", busy); end
      end
      if (c == 51) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL normal_busy_hold: got %b want 1", busy); end
      end
      if (c == 60) begin
        checks++; if (render_cycles !== (STATS_ON ? 24'd50 : 24'd0)) begin errors++; $display("[TB] FAIL normal_render_cycles: got %0d want %0d", render_cycles, STATS_ON ? 50 : 0); end
      end
      if (c == 101) begin
        checks++; if (back_buf !== 1'b0 || frame_count !== 16'd0) begin errors++; $display("[TB] FAIL normal_swap_early: got back %b frames %0d want 0 0", back_buf, frame_count); end
      end
      if (c == 102) begin
        checks++; if (back_buf !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("[TB] FAIL normal_swap: got back %b frames %0d want 1 1", back_buf, frame_count); end
      end
    end
  endtask

  task automatic test_late_frame();
    doReset(1'b0);
    enable = 1'b1;
    for (int c = 0; c <= 34; c++) begin
      tick();
      vsync = (c == 0) || (c == 10) || (c == 30);
      clear_done = (c == 3); proj_done = (c == 6); draw_done = (c == 15);
      checks++; if (late !== (c == 11)) begin errors++; $display("[TB] FAIL late_pulse c%0d: got %b", c, late); end
      if (c == 11) begin
        checks++; if (late_count !== 8'd1) begin errors++; $display("[TB] FAIL late_count: got %0d want 1", late_count); end
      end
      if (c == 20) begin
        checks++; if (back_buf !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL late_no_swap: got back %b busy %b want 0 1", back_buf, busy); end
        checks++; if (render_cycles !== (STATS_ON ? 24'd15 : 24'd0)) begin errors++; $display("[TB] FAIL late_render_cycles: got %0d want %0d", render_cycles, STATS_ON ? 15 : 0); end
      end
      if (c == 32) begin
        checks++; if (back_buf !== 1'b1 || frame_count !== 16'd1 || late_count !== 8'd1) begin errors++; $display("[TB] FAIL late_swap: got back %b frames %0d late %0d want 1 1 1", back_buf, frame_count, late_count); end
      end
    end
  endtask

  task automatic test_back_to_back();
    doReset(1'b0);
    enable = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      tick();
      vsync = (c == 0) || (c == 12);
      clear_done = (c == 3); proj_done = (c == 6); draw_done = (c == 12);
      checks++; if (late !== 1'b0) begin errors++; $display("[TB] FAIL ontime_late c%0d: got %b want 0", c, late); end
      if (c == 13) begin
        checks++; if (busy !== 1'b1 || back_buf !== 1'b0 || clear_start !== 1'b0) begin errors++; $display("[TB] FAIL ontime_swap_cycle: got busy %b back %b clr %b want 1 0 0", busy, back_buf, clear_start); end
      end
      if (c == 14) begin
        checks++; if (back_buf !== 1'b1 || frame_count !== 16'd1 || clear_start !== 1'b1 || late_count !== 8'd0) begin errors++; $display("[TB] FAIL ontime_after_swap: got back %b frames %0d clr %b late %0d want 1 1 1 0", back_buf, frame_count, clear_start, late_count); end
      end
      if (c == 16) begin
        checks++; if (render_cycles !== (STATS_ON ? 24'd12 : 24'd0)) begin errors++; $display("[TB] FAIL ontime_render_cycles: got %0d want %0d", render_cycles, STATS_ON ? 12 : 0); end
      end
    end
  endtask

  task automatic test_level_done();
    doReset(1'b0);
    enable = 1'b1;
    clear_done = 1'b1; proj_done = 1'b1; draw_done = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      tick();
      vsync = (c == 0);
      checks++; if ({clear_start, proj_start, draw_start} !== {c == 1, c == 3, c == 5}) begin errors++; $display("[TB] FAIL level_done_strobes c%0d: got %b", c, {clear_start, proj_start, draw_start}); end
      if (c == 7) begin
        checks++; if (busy !== 1'b1 || back_buf !== 1'b0) begin errors++; $display("[TB] FAIL level_done_hold: got busy %b back %b want 1 0", busy, back_buf); end
      end
      if (c == 8) begin
        checks++; if (render_cycles !== (STATS_ON ? 24'd6 : 24'd0)) begin errors++; $display("[TB] FAIL level_done_render: got %0d want %0d", render_cycles, STATS_ON ? 6 : 0); end
      end
    end
    clear_done = 1'b0; proj_done = 1'b0; draw_done = 1'b0;
  endtask

  task automatic test_enable_drop();
    doReset(1'b0);
    enable = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      tick();
      vsync = (c == 0) || (c == 20) || (c == 30) || (c == 40);
      if (c == 4) enable = 1'b0;
      clear_done = (c == 3); proj_done = (c == 8); draw_done = (c == 12);
      checks++; if (clear_start !== (c == 1)) begin errors++; $display("[TB] FAIL drop_clear_start c%0d: got %b", c, clear_start); end
      if (c == 21) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_swap_busy: got %b want 1", busy); end
      end
      if (c >= 22) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle_busy c%0d: got %b want 0", c, busy); end
      end
      if (c == 22 || c == 45) begin
        checks++; if (frame_count !== 16'd1 || back_buf !== 1'b1) begin errors++; $display("[TB] FAIL drop_frames c%0d: got frames %0d back %b want 1 1", c, frame_count, back_buf); end
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset(1'b0);
    enable = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      tick();
      vsync = (c == 0);
      clear_done = (c == 2);
      Reset = (c == 3);
      if (c == 3) begin
        checks++; if (proj_start !== 1'b1) begin errors++; $display("[TB] FAIL midreset_proj_start: got %b want 1", proj_start); end
      end
      if (c >= 4) begin
        checks++; if (busy !== 1'b0 || proj_start !== 1'b0 || clear_start !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle c%0d: got busy %b proj %b clr %b want 0 0 0", c, busy, proj_start, clear_start); end
      end
    end
  endtask

  task automatic test_frame_wrap();
    doReset(1'b0);
    sEnable = 1'b1; sClearDone = 1'b1; sProjDone = 1'b1; sDrawDone = 1'b1;
    for (int c = 0; c <= 85; c++) begin
      tick();
      sVsync = ((c % 20) == 0) && (c <= 80);
      if (c == 62) begin
        checks++; if (sFrame !== 2'd3) begin errors++; $display("[TB] FAIL wrap_frames3: got %0d want 3", sFrame); end
      end
      if (c == 82) begin
        checks++; if (sFrame !== 2'd0 || sBack !== 1'b0) begin errors++; $display("[TB] FAIL wrap_frames0: got frames %0d back %b want 0 0", sFrame, sBack); end
      end
      if (c == 85) begin
        checks++; if (sLateCount !== 2'd0) begin errors++; $display("[TB] FAIL wrap_no_late: got %0d want 0", sLateCount); end
      end
    end
  endtask

  task automatic test_late_saturate();
    doReset(1'b0);
    sEnable = 1'b1; sClearDone = 1'b1; sProjDone = 1'b1; sDrawDone = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      tick();
      sVsync = (c == 0) || (c == 10) || (c == 14) || (c == 18) || (c == 22) || (c == 26);
      if (c == 15) begin
        checks++; if (sLateCount !== 2'd2) begin errors++; $display("[TB] FAIL sat_late2: got %0d want 2", sLateCount); end
      end
      if (c == 19) begin
        checks++; if (sLateCount !== 2'd3) begin errors++; $display("[TB] FAIL sat_late3: got %0d want 3", sLateCount); end
      end
      if (c == 27) begin
        checks++; if (sLate !== 1'b1) begin errors++; $display("[TB] FAIL sat_pulse: got %b want 1", sLate); end
      end
      if (c == 30) begin
        checks++; if (sLateCount !== 2'd3 || sBack !== 1'b0) begin errors++; $display("[TB] FAIL sat_hold: got late %0d back %b want 3 0", sLateCount, sBack); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vsync_high_at_reset();
    test_normal_frame();
    test_late_frame();
    test_back_to_back();
    test_level_done();
    test_enable_drop();
    test_reset_mid();
    test_frame_wrap();
    test_late_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
